// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg: shared state encoding and default sizing for the timer arbiter slice
package timer_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_VALUE_W = 6;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
endpackage

// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: requester bundle and timer handshake between the arbiter and its parent
interface timer_arbiter_if
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int VALUE_W = DEF_VALUE_W,
  parameter int ID_W = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0] req_in;
  logic [NUM_REQ-1:0] cancel_in;
  logic [NUM_REQ*VALUE_W-1:0] value_in;
  logic [NUM_REQ-1:0] busy_out;
  logic [NUM_REQ-1:0] done_out;
  logic active_out;
  logic [ID_W-1:0] owner_out;
  logic timer_start_out;
  logic [VALUE_W-1:0] timer_value_out;
  logic timer_expired_in;
  modport slave (
    input req_in, cancel_in, value_in, timer_expired_in,
    output busy_out, done_out, active_out, owner_out, timer_start_out, timer_value_out
  );
  modport master (
    output req_in, cancel_in, value_in, timer_expired_in,
    input busy_out, done_out, active_out, owner_out, timer_start_out, timer_value_out
  );
endinterface

// File: rtl/timer_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search for the first pending bit after the pointer
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] cand;
  // Scan from the farthest offset down so the nearest pending slot is written last.
  always_comb begin
    found = |pending;
    idx = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = W'((int'(ptr) + k) % N);
      idx = pending[cand] ? cand : idx;
    end
  end
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one countdown timer among requesters, with done pulses on expiry
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int VALUE_W = DEF_VALUE_W,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input logic clk_in,
  input logic rst_in,
  timer_arbiter_if.slave bus
);
  state_t state, state_n;
  logic [NUM_REQ-1:0] pending, pending_n, grant_mask, owner_mask;
  logic [VALUE_W-1:0] vals [NUM_REQ];
  logic [VALUE_W-1:0] cur_val;
  logic [ID_W-1:0] owner, ptr, pick;
  logic exp_q, found, active, owner_cancel, exp_edge, grant;
  rr_picker #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .pending(pending),
    .ptr(ptr),
    .found(found),
    .idx(pick)
  );
  always_comb begin
    active = state == START || state == WAIT;
    owner_mask = NUM_REQ'(1) << owner;
    owner_cancel = active && bus.cancel_in[owner];
    exp_edge = bus.timer_expired_in & ~exp_q;
    grant = state == IDLE && found;
    grant_mask = grant ? NUM_REQ'(1) << pick : '0;
    // Cancel is applied last so it beats a same-cycle request.
    pending_n = ((pending & ~grant_mask) | bus.req_in) & ~bus.cancel_in;
    state_n = state;
    unique case (state)
      IDLE:    state_n = found ? START : IDLE;
      START:   state_n = owner_cancel ? IDLE : WAIT;
      WAIT:    state_n = owner_cancel ? IDLE : exp_edge ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  assign bus.active_out = active;
  assign bus.owner_out = owner;
  assign bus.timer_start_out = state == START;
  assign bus.timer_value_out = state == START ? cur_val : '0;
  assign bus.done_out = state == DONE ? owner_mask : '0;
  assign bus.busy_out = pending | (active ? owner_mask : '0);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      pending <= '0;
      owner <= '0;
      cur_val <= '0;
      ptr <= ID_W'(NUM_REQ - 1);
      exp_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) vals[i] <= '0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      exp_q <= bus.timer_expired_in;
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_in[i]) vals[i] <= bus.value_in[i*VALUE_W +: VALUE_W];
      if (grant) begin
        owner <= pick;
        cur_val <= vals[pick];
        ptr <= pick;
      end
    end
  end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed vectors plus multi-cycle sequences against a 10-cycle-tick timer model
module tb_timer_arbiter;
  import timer_arb_pkg::*;
  localparam int N = 4;
  localparam int VW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  timer_arbiter_if #(.NUM_REQ(N), .VALUE_W(VW)) bus ();
  timer_arbiter #(.NUM_REQ(N), .VALUE_W(VW)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  always #5 clk = ~clk;

  // Timer model: loads on start, counts down on each tick, holds expired until the next tick.
  int div = 0;
  logic [VW-1:0] t_cnt = '0;
  logic t_run = 1'b0, t_exp = 1'b0, use_model = 1'b0, force_exp = 1'b0;
  always @(posedge clk) begin
    div <= (div == 9) ? 0 : div + 1;
    if (bus.timer_start_out) begin
      t_cnt <= bus.timer_value_out;
      t_run <= 1'b1;
      t_exp <= 1'b0;
    end else if (div == 9) begin
      if (t_run && t_cnt == 0) begin
        t_exp <= 1'b1;
        t_run <= 1'b0;
      end else begin
        t_exp <= 1'b0;
        if (t_run) t_cnt <= t_cnt - 1'b1;
      end
    end
  end
  assign bus.timer_expired_in = use_model ? t_exp : force_exp;

  int errs = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {bus.busy_out, bus.done_out, bus.active_out, bus.owner_out, bus.timer_start_out, bus.timer_value_out};
  endfunction

  function automatic logic [23:0] pv(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
    return {d, c, b, a};
  endfunction

  typedef struct {
    logic [3:0] req, cancel;
    logic [23:0] val;
    logic ex;
    logic [17:0] exp_out;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] c, input logic [23:0] v, input logic e,
                              input logic [3:0] b, input logic [3:0] d, input logic a, input logic [1:0] o,
                              input logic s, input logic [5:0] tv);
    vec_t x;
    x.req = r; x.cancel = c; x.val = v; x.ex = e;
    x.exp_out = {b, d, a, o, s, tv};
    return x;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((t_run || t_exp) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timer_idle", 64'(n < 300), 64'd1);
  endtask

  logic [1:0] st_own[$];
  logic [5:0] st_val[$];
  logic [1:0] done_ord[$];
  logic multi;

  // Runs until `want` done pulses, re-requesting any requester in `retrig` when it completes.
  task automatic run(input int want, input logic [3:0] retrig, input int maxc);
    int n = 0;
    st_own.delete(); st_val.delete(); done_ord.delete();
    multi = 1'b0;
    while (done_ord.size() < want && n < maxc) begin
      @(negedge clk);
      n++;
      bus.req_in = bus.done_out & retrig;
      if (bus.timer_start_out) begin
        st_own.push_back(bus.owner_out);
        st_val.push_back(bus.timer_value_out);
      end
      if ($countones(bus.done_out) > 1) multi = 1'b1;
      for (int i = 0; i < N; i++) if (bus.done_out[i]) done_ord.push_back(2'(i));
    end
    bus.req_in = '0;
    chk("run_budget", 64'(n < maxc), 64'd1);
  endtask

  vec_t v[18];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic ok, bad;
    bus.req_in = '0;
    bus.cancel_in = '0;
    bus.value_in = '0;
    v[0]  = mk(4'h1, 4'h0, pv(6'd5, 6'd0, 6'd0, 6'd0), 1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0, 6'd0);
    v[1]  = mk(4'h0, 4'h0, '0, 1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b1, 6'd5);
    v[2]  = mk(4'h0, 4'h0, '0, 1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0, 6'd0);
    v[3]  = mk(4'h0, 4'h0, '0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 1'b0, 6'd0);
    v[4]  = mk(4'h0, 4'h0, '0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 6'd0);
    v[5]  = mk(4'ha, 4'h0, pv(6'd0, 6'd2, 6'd0, 6'd7), 1'b0, 4'ha, 4'h0, 1'b0, 2'd0, 1'b0, 6'd0);
    v[6]  = mk(4'h0, 4'h0, '0, 1'b0, 4'ha, 4'h0, 1'b1, 2'd1, 1'b1, 6'd2);
    v[7]  = mk(4'h0, 4'h0, '0, 1'b1, 4'ha, 4'h0, 1'b1, 2'd1, 1'b0, 6'd0);
    v[8]  = mk(4'h0, 4'h0, '0, 1'b1, 4'ha, 4'h0, 1'b1, 2'd1, 1'b0, 6'd0);
    v[9]  = mk(4'h0, 4'h0, '0, 1'b0, 4'ha, 4'h0, 1'b1, 2'd1, 1'b0, 6'd0);
    v[10] = mk(4'h0, 4'h0, '0, 1'b1, 4'h8, 4'h2, 1'b0, 2'd1, 1'b0, 6'd0);
    v[11] = mk(4'h0, 4'h0, '0, 1'b0, 4'h8, 4'h0, 1'b0, 2'd1, 1'b0, 6'd0);
    v[12] = mk(4'h0, 4'h0, '0, 1'b0, 4'h8, 4'h0, 1'b1, 2'd3, 1'b1, 6'd7);
    v[13] = mk(4'h0, 4'h0, '0, 1'b0, 4'h8, 4'h0, 1'b1, 2'd3, 1'b0, 6'd0);
    v[14] = mk(4'h0, 4'h8, '0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd3, 1'b0, 6'd0);
    v[15] = mk(4'h0, 4'h0, '0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd3, 1'b0, 6'd0);
    v[16] = mk(4'h4, 4'h4, pv(6'd0, 6'd0, 6'd9, 6'd0), 1'b0, 4'h0, 4'h0, 1'b0, 2'd3, 1'b0, 6'd0);
    v[17] = mk(4'h0, 4'h0, '0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd3, 1'b0, 6'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", 64'(outs()), 64'd0);
    for (int i = 0; i < 18; i++) begin
      bus.req_in = v[i].req;
      bus.cancel_in = v[i].cancel;
      bus.value_in = v[i].val;
      force_exp = v[i].ex;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(v[i].exp_out));
    end
    bus.req_in = '0; bus.cancel_in = '0; bus.value_in = '0; force_exp = 1'b0;
    use_model = 1'b1;

    // Single request, value 3
    wait_idle(); do_reset();
    bus.value_in = pv(6'd3, 6'd0, 6'd0, 6'd0); bus.req_in = 4'h1;
    @(negedge clk); bus.req_in = '0;
    chk("A_busy_pending", 64'(bus.busy_out), 64'h1);
    chk("A_no_start_yet", 64'(bus.timer_start_out), 64'd0);
    @(negedge clk);
    chk("A_start_val3", 64'({bus.timer_start_out, bus.timer_value_out}), 64'({1'b1, 6'd3}));
    ok = 1'b1; c = 0;
    while (c < 100) begin
      @(negedge clk); c++;
      if (t_exp) break;
      ok &= bus.busy_out == 4'h1 && bus.done_out == 4'h0 && !bus.timer_start_out;
    end
    chk("A_expiry_seen", 64'(c < 100), 64'd1);
    chk("A_busy_held_one_start", 64'(ok), 64'd1);
    chk("A_no_done_at_rise", 64'(bus.done_out), 64'd0);
    @(negedge clk);
    chk("A_done_pulse", 64'(bus.done_out), 64'h1);
    @(negedge clk);
    chk("A_done_once_idle", 64'({bus.busy_out, bus.done_out}), 64'd0);

    // Simultaneous requests 0,1,2
    wait_idle(); do_reset();
    bus.value_in = pv(6'd1, 6'd2, 6'd3, 6'd0); bus.req_in = 4'h7;
    @(negedge clk); bus.req_in = '0;
    run(3, 4'h0, 400);
    chk("B_grant_count", 64'(st_own.size()), 64'd3);
    chk("B_grant_order", 64'({st_own[0], st_own[1], st_own[2]}), 64'({2'd0, 2'd1, 2'd2}));
    chk("B_start_values", 64'({st_val[0], st_val[1], st_val[2]}), 64'({6'd1, 6'd2, 6'd3}));
    chk("B_done_order", 64'({done_ord[0], done_ord[1], done_ord[2]}), 64'({2'd0, 2'd1, 2'd2}));
    chk("B_single_done_bit", 64'(multi), 64'd0);

    // Fairness with requester 1 retriggering
    wait_idle(); do_reset();
    bus.value_in = pv(6'd0, 6'd1, 6'd1, 6'd1); bus.req_in = 4'he;
    @(negedge clk); bus.req_in = '0;
    run(4, 4'h2, 600);
    chk("C_grant_order", 64'({st_own[0], st_own[1], st_own[2], st_own[3]}), 64'({2'd1, 2'd2, 2'd3, 2'd1}));

    // Cancel owner in WAIT with another pending
    wait_idle(); do_reset();
    bus.value_in = pv(6'd4, 6'd1, 6'd0, 6'd0); bus.req_in = 4'h3;
    @(negedge clk); bus.req_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("D_wait_owner0", 64'({bus.active_out, bus.owner_out, bus.timer_start_out}), 64'({1'b1, 2'd0, 1'b0}));
    bus.cancel_in = 4'h1;
    @(negedge clk); bus.cancel_in = '0;
    chk("D_cancel_no_done", 64'({bus.active_out, bus.done_out}), 64'd0);
    c = 1;
    while (!bus.timer_start_out && c < 3) begin
      @(negedge clk); c++;
    end
    chk("D_next_start_fast", 64'({bus.timer_start_out, bus.owner_out}), 64'({1'b1, 2'd1}));
    bad = 1'b0; c = 0;
    while (bus.done_out == 4'h0 && c < 100) begin
      @(negedge clk); c++;
    end
    chk("D_done_owner1", 64'(bus.done_out), 64'h2);
    // Stale expiry after cancel with nothing pending
    wait_idle(); do_reset();
    bus.value_in = pv(6'd1, 6'd0, 6'd0, 6'd0); bus.req_in = 4'h1;
    @(negedge clk); bus.req_in = '0;
    @(negedge clk);
    @(negedge clk);
    bus.cancel_in = 4'h1;
    @(negedge clk); bus.cancel_in = '0;
    c = 0;
    while (c < 100) begin
      @(negedge clk); c++;
      bad |= bus.done_out != 4'h0;
      if (t_exp) break;
    end
    repeat (3) begin
      @(negedge clk);
      bad |= bus.done_out != 4'h0 || bus.active_out;
    end
    chk("D_stale_expiry_seen", 64'(c < 100), 64'd1);
    chk("D_stale_no_done", 64'(bad), 64'd0);

    // Same-cycle request and cancel, then value 0
    wait_idle(); do_reset();
    bus.value_in = pv(6'd0, 6'd0, 6'd5, 6'd0); bus.req_in = 4'h4; bus.cancel_in = 4'h4;
    @(negedge clk); bus.req_in = '0; bus.cancel_in = '0;
    chk("E_req_cancel_busy", 64'(bus.busy_out), 64'd0);
    @(negedge clk);
    chk("E_still_idle", 64'({bus.busy_out, bus.active_out}), 64'd0);
    bus.value_in = '0; bus.req_in = 4'h4;
    @(negedge clk); bus.req_in = '0;
    @(negedge clk);
    chk("E_start_zero", 64'({bus.timer_start_out, bus.owner_out, bus.timer_value_out}), 64'({1'b1, 2'd2, 6'd0}));
    c = 0;
    while (bus.done_out == 4'h0 && c < 40) begin
      @(negedge clk); c++;
    end
    chk("E_done_after_one_tick", 64'({bus.done_out, c <= 13}), 64'({4'h4, 1'b1}));

    // Reset pulse during WAIT
    wait_idle(); do_reset();
    bus.value_in = pv(6'd2, 6'd0, 6'd0, 6'd0); bus.req_in = 4'h1;
    @(negedge clk); bus.req_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("F_in_wait", 64'({bus.active_out, bus.timer_start_out}), 64'({1'b1, 1'b0}));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("F_reset_outputs", 64'(outs()), 64'd0);
    bad = 1'b0; c = 0;
    while (c < 100) begin
      @(negedge clk); c++;
      bad |= bus.done_out != 4'h0 || bus.active_out;
      if (t_exp) break;
    end
    repeat (3) begin
      @(negedge clk);
      bad |= bus.done_out != 4'h0 || bus.active_out;
    end
    chk("F_expiry_seen", 64'(c < 100), 64'd1);
    chk("F_no_done_after_reset", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
